fp_add_sub_align: RTL
=====================

// Module: fp_add_sub_align
// PURPOSE
//  Pre-adder alignment stage of the FP32 add/sub datapath. Sits directly upstream of the mantissa carry-lookahead adder.
//  - Unpacks two IEEE-754 single operands and resolves effective add/sub.
//  - Orders operands by magnitude and right-shifts the smaller mantissa by the exponent difference, with guard/round/sticky.
//  - Delivers aligned 27-bit mantissas, the common exponent and special-case flags over a 2-stage valid/ready pipeline.
// PARAMETERS
//  EXP_W   8    exponent width
//  FRAC_W  23   stored fraction width
//  MANT_W  27   aligned mantissa width = hidden(1) + FRAC_W + G,R,S (3)
// PORTS
//  i_clk         in   1       clock, rising edge
//  i_rst_n       in   1       asynchronous active-low reset
//  i_valid       in   1       input transaction valid
//  o_ready       out  1       stage can accept input this cycle
//  i_op_a        in   32      operand A (FP32)
//  i_op_b        in   32      operand B (FP32)
//  i_sub         in   1       1 = A-B, 0 = A+B
//  o_valid       out  1       output transaction valid
//  i_ready       in   1       downstream accepts output
//  o_exp         out  EXP_W   exponent of larger-magnitude operand
//  o_mant_l      out  MANT_W  larger mantissa {hidden,frac,3'b000}
//  o_mant_s      out  MANT_W  smaller mantissa, aligned, [0]=sticky
//  o_sign        out  1       result sign (sign of larger operand)
//  o_eff_sub     out  1       effective subtraction (sign_a^sign_b^i_sub)
//  o_is_nan      out  1       result is NaN
//  o_is_inf      out  1       result is infinity
// BEHAVIOUR
//  - Reset: both stage valid flags and all output registers clear to 0; o_ready=1 after reset.
//    Reset asserted mid-operation flushes both stages; no output transaction is produced.
//  - Handshake: transfer on valid&ready at each boundary. Stage n loads when empty or its contents are consumed.
//    o_ready = !v1 | (!v2 | i_ready). Latency 2 cycles; full throughput of 1/cycle.
//    Output data is held stable while o_valid & !i_ready.
//  - Stage 1:
//    - Unpack operands; eff sign of B = sign_b ^ i_sub. Diff = |exp_a - exp_b|, computed by 8-bit subtract with borrow.
//    - Swap so the larger magnitude is "l": exp first, then mantissa on equal exp. Exact tie: A is "l".
//  - Stage 2:
//    - Shift mant_s right by diff into MANT_W bits; shifted-out bits OR into [0] (sticky).
//    - diff >= MANT_W: o_mant_s = {26'b0, |mant}.
//  - Sign: sign of the "l" operand. eff_sub with equal magnitudes gives o_sign=0 (+0, RNE).
//  - Specials:
//    - Either operand NaN -> o_is_nan=1.
//    - inf with eff_sub against inf -> o_is_nan=1.
//    - Otherwise any inf -> o_is_inf=1, o_sign = sign of the inf operand.
//    - Flags are valid alongside the mantissas; mantissa fields are don't-care when either flag is set.
// CONFIGURATION
//  FP_ALIGN_SUBNORM_EN defined:
//    exp==0 operands are subnormal: hidden bit=0, effective exponent=1.
//  FP_ALIGN_SUBNORM_EN undefined:
//    exp==0 operands flush to zero: mantissa=0, exponent=0, sign kept.
// STRUCTURE
//  - fp_add_sub_pkg:
//    - EXP_W/FRAC_W/MANT_W localparams.
//    - typedef fp32_t {sign,exp,frac}.
//    - typedef align_s1_t (stage-1 payload).
//    - EXP_MAX=8'hFF.
//  - Sub-module fp_shift_right_sticky: MANT_W input, 8-bit shift amount, sticky-OR output. Combinational, used by stage 2.
// TESTING
//  1. A=3F800000, B=3F800000, sub=0 -> 2 cycles later:
//     exp=7F, mant_l=27'h4000000, mant_s=27'h4000000, eff_sub=0, sign=0.
//  2. A=3F000000, B=3F800000, sub=0 -> swap:
//     exp=7F, mant_l=27'h4000000, mant_s=27'h2000000, sign=0.
//  3. Shift and sticky:
//     a. A=4B800000, B=3F800001 (diff 24) -> mant_s=27'h0000005.
//     b. A=53800000, B=3F800000 (diff 40) -> mant_s=27'h0000001.
//  4. Specials:
//     a. A=7F800000, B=7F800000, sub=1 -> o_is_nan=1.
//     b. A=3F800000, B=3F800000, sub=1 -> eff_sub=1, sign=0.
//     c. A=FF800000, B=3F800000 -> is_inf=1, sign=1.
//  5. Backpressure: 4 back-to-back inputs with i_ready=0.
//     o_ready drops after 2 accepted; outputs held stable; release -> all 4 emerge in order, none lost or duplicated.
//  6. Reset mid-op: deassert i_rst_n with both stages valid -> o_valid=0 immediately.
//     Subnormal: B=00400000, A=00000000:
//       with FP_ALIGN_SUBNORM_EN -> exp=01, mant_l=27'h2000000.
//       without -> exp=00, mant_l=0.

Source files
------------

// File: rtl/fp_add_sub_pkg.sv
// Shared types and constants for the FP32 add/sub pre-adder alignment stage.
// Provides field widths, the FP32 layout, the stage-1 payload and the operand unpack helper.
// Build option: FP_ALIGN_SUBNORM_EN selects subnormal support (defined) or flush-to-zero (undefined).
package fp_add_sub_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = 27;            // hidden + fraction + guard/round/sticky
   localparam int SIG_W  = FRAC_W + 1;    // hidden + fraction, before GRS extension

   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   // Operand after subnormal / flush-to-zero treatment.
   typedef struct packed {
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] sig;
   } unp_t;

   // Payload carried from stage 1 (ordering) to stage 2 (alignment shift).
   typedef struct packed {
      logic [EXP_W-1:0] exp_l;
      logic [EXP_W-1:0] diff;
      logic [SIG_W-1:0] sig_l;
      logic [SIG_W-1:0] sig_s;
      logic             sign;
      logic             eff_sub;
      logic             is_nan;
      logic             is_inf;
   } align_s1_t;

   // exp==0 is either a true subnormal (hidden 0, exponent treated as 1)
   // or flushed to a signed zero; every other exponent gets the hidden 1.
   function automatic unp_t fp_unpack(fp32_t x);
      unp_t u;
      if (x.exp == '0) begin
`ifdef FP_ALIGN_SUBNORM_EN
         u.exp = 8'd1;
         u.sig = {1'b0, x.frac};
`else
         u.exp = '0;
         u.sig = '0;
`endif
      end else begin
         u.exp = x.exp;
         u.sig = {1'b1, x.frac};
      end
      return u;
   endfunction

endpackage

// File: rtl/fp_shift_right_sticky.sv
// Right shift of a mantissa by an 8-bit amount, OR-ing every shifted-out bit into bit 0.
// Ports: mant_i (W bits), shamt_i (8 bits) -> mant_o (W bits).
// Purely combinational; shifts of W or more leave only the sticky bit.
module fp_shift_right_sticky
   import fp_add_sub_pkg::*;
#(
   parameter int W = MANT_W
) (
   input  logic [W-1:0] mant_i,
   input  logic [7:0]   shamt_i,
   output logic [W-1:0] mant_o
);

   logic [W-1:0] shifted;
   logic [W-1:0] lost_mask;
   logic         sticky;

   // A shift amount >= W yields zero for the data and an all-ones mask,
   // so the large-shift case collapses to {0..0, |mant_i} without a branch.
   assign shifted   = mant_i >> shamt_i;
   assign lost_mask = ~({W{1'b1}} << shamt_i);
   assign sticky    = |(mant_i & lost_mask);
   assign mant_o    = {shifted[W-1:1], shifted[0] | sticky};

endmodule

// File: rtl/fp_add_sub_align.sv
// FP32 add/sub alignment: unpack, order by magnitude, align smaller mantissa with sticky, flag specials.
// Ports: i_valid/o_ready in, o_valid/i_ready out, operands i_op_a/i_op_b/i_sub -> o_exp, o_mant_l, o_mant_s, o_sign, o_eff_sub, o_is_nan, o_is_inf.
// Latency 2 cycles, 1/cycle throughput; outputs held while o_valid & !i_ready. FP_ALIGN_SUBNORM_EN enables subnormals.
module fp_add_sub_align
   import fp_add_sub_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [31:0]       i_op_a,
   input  logic [31:0]       i_op_b,
   input  logic              i_sub,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [EXP_W-1:0]  o_exp,
   output logic [MANT_W-1:0] o_mant_l,
   output logic [MANT_W-1:0] o_mant_s,
   output logic              o_sign,
   output logic              o_eff_sub,
   output logic              o_is_nan,
   output logic              o_is_inf
);

   // ---------------- Stage 1: unpack and order ----------------
   fp32_t     op_a, op_b;
   unp_t      ua, ub;
   align_s1_t s1_d, s1_q;
   logic      v1_q, v2_q;
   logic      adv2;

   logic [EXP_W:0]   ediff;
   logic             borrow, exp_eq, mag_eq, swap;
   logic             sign_b_eff, eff_sub;
   logic             nan_a, nan_b, inf_a, inf_b;

   assign op_a = i_op_a;
   assign op_b = i_op_b;
   assign ua   = fp_unpack(op_a);
   assign ub   = fp_unpack(op_b);

   // 9-bit subtract: the top bit is the borrow, i.e. exp_b > exp_a.
   assign ediff  = {1'b0, ua.exp} - {1'b0, ub.exp};
   assign borrow = ediff[EXP_W];
   assign exp_eq = (ua.exp == ub.exp);
   assign mag_eq = exp_eq && (ua.sig == ub.sig);
   // Exact ties keep A as the larger operand.
   assign swap   = borrow || (exp_eq && (ua.sig < ub.sig));

   assign sign_b_eff = op_b.sign ^ i_sub;
   assign eff_sub    = op_a.sign ^ sign_b_eff;

   // Specials are decoded from the raw fields; unpacking never touches exp==FF.
   assign nan_a = (op_a.exp == EXP_MAX) && (op_a.frac != '0);
   assign nan_b = (op_b.exp == EXP_MAX) && (op_b.frac != '0);
   assign inf_a = (op_a.exp == EXP_MAX) && (op_a.frac == '0);
   assign inf_b = (op_b.exp == EXP_MAX) && (op_b.frac == '0);

   always_comb begin
      s1_d         = '0;
      s1_d.eff_sub = eff_sub;
      s1_d.diff    = borrow ? (ub.exp - ua.exp) : ediff[EXP_W-1:0];
      if (swap) begin
         s1_d.exp_l = ub.exp;
         s1_d.sig_l = ub.sig;
         s1_d.sig_s = ua.sig;
      end else begin
         s1_d.exp_l = ua.exp;
         s1_d.sig_l = ua.sig;
         s1_d.sig_s = ub.sig;
      end

      s1_d.is_nan = nan_a || nan_b || (inf_a && inf_b && eff_sub);
      s1_d.is_inf = !s1_d.is_nan && (inf_a || inf_b);

      if (s1_d.is_inf) begin
         s1_d.sign = inf_a ? op_a.sign : sign_b_eff;
      end else if (eff_sub && mag_eq) begin
         s1_d.sign = 1'b0;                  // x - x rounds to +0 under RNE
      end else begin
         s1_d.sign = swap ? sign_b_eff : op_a.sign;
      end
   end

   // ---------------- Handshake ----------------
   assign adv2    = !v2_q || i_ready;
   assign o_ready = !v1_q || adv2;
   assign o_valid = v2_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v1_q <= 1'b0;
         s1_q <= '0;
      end else if (o_ready) begin
         v1_q <= i_valid;
         if (i_valid) begin
            s1_q <= s1_d;
         end
      end
   end

   // ---------------- Stage 2: align ----------------
   logic [MANT_W-1:0] mant_s_d;

   fp_shift_right_sticky #(.W(MANT_W)) u_shift (
      .mant_i  ({s1_q.sig_s, 3'b000}),
      .shamt_i (s1_q.diff),
      .mant_o  (mant_s_d)
   );

   logic [EXP_W-1:0]  exp_q;
   logic [MANT_W-1:0] mant_l_q, mant_s_q;
   logic              sign_q, eff_sub_q, is_nan_q, is_inf_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v2_q      <= 1'b0;
         exp_q     <= '0;
         mant_l_q  <= '0;
         mant_s_q  <= '0;
         sign_q    <= 1'b0;
         eff_sub_q <= 1'b0;
         is_nan_q  <= 1'b0;
         is_inf_q  <= 1'b0;
      end else if (adv2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            exp_q     <= s1_q.exp_l;
            mant_l_q  <= {s1_q.sig_l, 3'b000};
            mant_s_q  <= mant_s_d;
            sign_q    <= s1_q.sign;
            eff_sub_q <= s1_q.eff_sub;
            is_nan_q  <= s1_q.is_nan;
            is_inf_q  <= s1_q.is_inf;
         end
      end
   end

   assign o_exp     = exp_q;
   assign o_mant_l  = mant_l_q;
   assign o_mant_s  = mant_s_q;
   assign o_sign    = sign_q;
   assign o_eff_sub = eff_sub_q;
   assign o_is_nan  = is_nan_q;
   assign o_is_inf  = is_inf_q;

endmodule
